event_ingress_buffer: RTL and testbench



---
 rtl/event_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/event_ingress_buffer.sv | 139 +++++++++++++
 tb/tb_event_ingress_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// Shared constants, default event layout and width helper for the event ingress path.
package event_pkg;

   localparam int unsigned STAT_CNT_W   = 16;
   localparam int unsigned DEF_BIT_TIME = 32;
   localparam int unsigned DEF_BIT_X    = 8;
   localparam int unsigned DEF_BIT_Y    = 8;

   // Default-width event; modules built with other widths declare the same layout locally.
   typedef struct packed {
      logic [DEF_BIT_TIME-1:0] timestamp;
      logic [DEF_BIT_X-1:0]    x;
      logic [DEF_BIT_Y-1:0]    y;
      logic                    polarity;
   } event_t;

   function automatic int unsigned event_width(input int unsigned tw, input int unsigned xw,
                                               input int unsigned yw);
      return tw + xw + yw + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty and a registered occupancy count.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [AW:0]      r_level;
   logic             w_wr;
   logic             w_rd;

   assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign empty   = (r_wptr == r_rptr);
   assign w_wr    = wr_en && !full;
   assign w_rd    = rd_en && !empty;
   assign rd_data = r_mem[r_rptr[AW-1:0]];
   assign level   = r_level;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
         r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/event_ingress_buffer.sv
// Event ingress: filters raw DVS events, buffers survivors and issues paced strobes to the core.
// Define EVT_STATS_EN to add saturating drop counters drop_range_cnt and drop_ts_cnt.
module event_ingress_buffer
   import event_pkg::*;
#(
   parameter int unsigned MAX_X_COORD    = 240,
   parameter int unsigned MAX_Y_COORD    = 180,
   parameter int unsigned INPUT_BIT_TIME = 32,
   parameter int unsigned INPUT_BIT_X    = 8,
   parameter int unsigned INPUT_BIT_Y    = 8,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned ISSUE_GAP      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [INPUT_BIT_TIME-1:0]   in_timestamp,
   input  logic [INPUT_BIT_X-1:0]      in_x,
   input  logic [INPUT_BIT_Y-1:0]      in_y,
   input  logic                        in_polarity,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        core_ready,
   output logic [INPUT_BIT_TIME-1:0]   timestamp,
   output logic [INPUT_BIT_X-1:0]      x_coord,
   output logic [INPUT_BIT_Y-1:0]      y_coord,
   output logic                        polarity,
   output logic                        is_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef EVT_STATS_EN
   ,
   output logic [STAT_CNT_W-1:0]       drop_range_cnt,
   output logic [STAT_CNT_W-1:0]       drop_ts_cnt
`endif
);

   localparam int unsigned GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
   localparam int unsigned EW = event_width(INPUT_BIT_TIME, INPUT_BIT_X, INPUT_BIT_Y);

   typedef struct packed {
      logic [INPUT_BIT_TIME-1:0] timestamp;
      logic [INPUT_BIT_X-1:0]    x;
      logic [INPUT_BIT_Y-1:0]    y;
      logic                      polarity;
   } evt_t;

   evt_t                      w_in_evt;
   evt_t                      w_head_evt;
   evt_t                      r_out;
   logic [EW-1:0]             w_head_raw;
   logic                      w_full;
   logic                      w_empty;
   logic                      w_accept;
   logic                      w_drop_range;
   logic                      w_drop_ts;
   logic                      w_wr;
   logic                      w_issue;
   logic [GW-1:0]             r_gap_cnt;
   logic [INPUT_BIT_TIME-1:0] r_last_ts;
   logic                      r_seen_first;
   logic                      r_valid;

   assign w_in_evt   = '{timestamp: in_timestamp, x: in_x, y: in_y, polarity: in_polarity};
   assign w_head_evt = evt_t'(w_head_raw);

   // Deasserting ready during reset guarantees nothing is written while state clears.
   assign in_ready     = !w_full && !reset;
   assign w_accept     = in_valid && in_ready;
   assign w_drop_range = (32'(in_x) >= MAX_X_COORD) || (32'(in_y) >= MAX_Y_COORD);
   assign w_drop_ts    = r_seen_first && (in_timestamp < r_last_ts);
   assign w_wr         = w_accept && !w_drop_range && !w_drop_ts;
   assign w_issue      = !w_empty && (r_gap_cnt == '0) && core_ready;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_wr),
      .wr_data (w_in_evt),
      .rd_en   (w_issue),
      .rd_data (w_head_raw),
      .full    (w_full),
      .empty   (w_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out        <= '0;
         r_valid      <= 1'b0;
         r_gap_cnt    <= '0;
         r_last_ts    <= '0;
         r_seen_first <= 1'b0;
      end else begin
         if (w_issue) begin
            r_out     <= w_head_evt;
            r_valid   <= 1'b1;
            r_gap_cnt <= GW'(ISSUE_GAP - 1);
         end else begin
            r_valid <= 1'b0;
            if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GW'(1);
         end
         if (w_wr) begin
            r_last_ts    <= in_timestamp;
            r_seen_first <= 1'b1;
         end
      end
   end

   assign timestamp = r_out.timestamp;
   assign x_coord   = r_out.x;
   assign y_coord   = r_out.y;
   assign polarity  = r_out.polarity;
   assign is_valid  = r_valid;

`ifdef EVT_STATS_EN
   logic [STAT_CNT_W-1:0] r_drop_range_cnt;
   logic [STAT_CNT_W-1:0] r_drop_ts_cnt;

   // A range failure takes precedence, so an event failing both counts once.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_range_cnt <= '0;
         r_drop_ts_cnt    <= '0;
      end else if (w_accept) begin
         if (w_drop_range) begin
            if (r_drop_range_cnt != '1) r_drop_range_cnt <= r_drop_range_cnt + STAT_CNT_W'(1);
         end else if (w_drop_ts) begin
            if (r_drop_ts_cnt != '1) r_drop_ts_cnt <= r_drop_ts_cnt + STAT_CNT_W'(1);
         end
      end
   end

   assign drop_range_cnt = r_drop_range_cnt;
   assign drop_ts_cnt    = r_drop_ts_cnt;
`endif

endmodule

// File: tb/tb_event_ingress_buffer.sv
// Self-checking bench for event_ingress_buffer: queue-based reference model plus directed cases.
module tb_event_ingress_buffer;

   localparam int unsigned MAXX  = 240;
   localparam int unsigned MAXY  = 180;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned GAP   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_timestamp;
   logic [7:0]  in_x, in_y;
   logic        in_polarity, in_valid, in_ready, core_ready;
   logic [31:0] timestamp;
   logic [7:0]  x_coord, y_coord;
   logic        polarity, is_valid;
   logic [4:0]  fifo_level;

   logic [31:0] g_in_timestamp, g_timestamp;
   logic [7:0]  g_in_x, g_in_y, g_x_coord, g_y_coord;
   logic        g_in_polarity, g_in_valid, g_in_ready, g_core_ready, g_polarity, g_is_valid;
   logic [4:0]  g_fifo_level;

`ifdef EVT_STATS_EN
   logic [15:0] drop_range_cnt, drop_ts_cnt, g_drop_range_cnt, g_drop_ts_cnt;
`endif

   always #5 clk = ~clk;

   event_ingress_buffer #(
      .MAX_X_COORD (MAXX), .MAX_Y_COORD (MAXY), .INPUT_BIT_TIME (32), .INPUT_BIT_X (8),
      .INPUT_BIT_Y (8), .FIFO_DEPTH (DEPTH), .ISSUE_GAP (GAP)
   ) u_dut (
      .clk (clk), .reset (reset), .in_timestamp (in_timestamp), .in_x (in_x), .in_y (in_y),
      .in_polarity (in_polarity), .in_valid (in_valid), .in_ready (in_ready),
      .core_ready (core_ready), .timestamp (timestamp), .x_coord (x_coord),
      .y_coord (y_coord), .polarity (polarity), .is_valid (is_valid), .fifo_level (fifo_level)
`ifdef EVT_STATS_EN
      , .drop_range_cnt (drop_range_cnt), .drop_ts_cnt (drop_ts_cnt)
`endif
   );

   event_ingress_buffer #(
      .MAX_X_COORD (MAXX), .MAX_Y_COORD (MAXY), .INPUT_BIT_TIME (32), .INPUT_BIT_X (8),
      .INPUT_BIT_Y (8), .FIFO_DEPTH (DEPTH), .ISSUE_GAP (1)
   ) u_dut_g1 (
      .clk (clk), .reset (reset), .in_timestamp (g_in_timestamp), .in_x (g_in_x),
      .in_y (g_in_y), .in_polarity (g_in_polarity), .in_valid (g_in_valid),
      .in_ready (g_in_ready), .core_ready (g_core_ready), .timestamp (g_timestamp),
      .x_coord (g_x_coord), .y_coord (g_y_coord), .polarity (g_polarity),
      .is_valid (g_is_valid), .fifo_level (g_fifo_level)
`ifdef EVT_STATS_EN
      , .drop_range_cnt (g_drop_range_cnt), .drop_ts_cnt (g_drop_ts_cnt)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: survivors queue in order, one issue per GAP cycles when core is ready.
   logic [48:0] m_q[$];
   logic [48:0] m_e;
   int          m_gap, m_rc, m_tc;
   logic [31:0] m_last, m_ts;
   logic [7:0]  m_x, m_y;
   logic        m_seen, m_valid, m_p, m_acc, m_iss;
   logic        m_init = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_q.delete();
         m_gap = 0; m_last = 0; m_seen = 0; m_valid = 0;
         m_ts = 0; m_x = 0; m_y = 0; m_p = 0; m_rc = 0; m_tc = 0;
      end else begin
         m_acc = in_valid && (m_q.size() < DEPTH);
         m_iss = (m_q.size() != 0) && (m_gap == 0) && core_ready;
         if (m_iss) begin
            m_e = m_q.pop_front();
            {m_ts, m_x, m_y, m_p} = m_e;
            m_valid = 1;
            m_gap   = GAP - 1;
         end else begin
            m_valid = 0;
            if (m_gap > 0) m_gap--;
         end
         if (m_acc) begin
            if (in_x >= MAXX || in_y >= MAXY) begin
               if (m_rc < 65535) m_rc++;
            end else if (m_seen && in_timestamp < m_last) begin
               if (m_tc < 65535) m_tc++;
            end else begin
               m_q.push_back({in_timestamp, in_x, in_y, in_polarity});
               m_last = in_timestamp;
               m_seen = 1;
            end
         end
      end
      m_init = 1'b1;
   end

   logic [48:0] st_q[$];
   int          st_cyc[$];

   always @(negedge clk) begin
      if (m_init) begin
         chk("in_ready", in_ready, !reset && (m_q.size() < DEPTH));
         chk("is_valid", is_valid, m_valid);
         chk("fifo_level", fifo_level, m_q.size());
         chk("timestamp", timestamp, m_ts);
         chk("x_coord", x_coord, m_x);
         chk("y_coord", y_coord, m_y);
         chk("polarity", polarity, m_p);
`ifdef EVT_STATS_EN
         chk("drop_range_cnt", drop_range_cnt, m_rc);
         chk("drop_ts_cnt", drop_ts_cnt, m_tc);
`endif
         if (is_valid) begin
            st_q.push_back({timestamp, x_coord, y_coord, polarity});
            st_cyc.push_back(cyc);
         end
      end
   end

   int acc_cyc;

   task automatic send(input logic [31:0] ts, input logic [7:0] x, input logic [7:0] y,
                       input logic p);
      int n = 0;
      in_valid = 1'b1; in_timestamp = ts; in_x = x; in_y = y; in_polarity = p;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("send_accept", in_ready, 1'b1);
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_chk);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 0; in_timestamp = 0; in_x = 0; in_y = 0; in_polarity = 0;
      core_ready = 0;
      g_in_valid = 0; g_in_timestamp = 0; g_in_x = 0; g_in_y = 0; g_in_polarity = 0;
      g_core_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1'b0);
      chk("reset_level", fifo_level, 0);
      chk("reset_valid", is_valid, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single event latency.
      core_ready = 1;
      st_q.delete(); st_cyc.delete();
      send(100, 10, 20, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("single_count", st_q.size(), 1);
      if (st_q.size() > 0) begin
         chk("single_latency", st_cyc[0] - acc_cyc, 1);
         chk("single_fields", st_q[0], {32'd100, 8'd10, 8'd20, 1'b1});
      end
      chk("single_level_idle", fifo_level, 0);

      // Range filter.
      st_q.delete(); st_cyc.delete();
      send(200, 240, 0, 0);
      send(201, 0, 180, 0);
      send(202, 239, 179, 1);
      repeat (8) @(posedge clk);
      #1;
      chk("range_count", st_q.size(), 1);
      if (st_q.size() > 0) chk("range_survivor", st_q[0], {32'd202, 8'd239, 8'd179, 1'b1});
`ifdef EVT_STATS_EN
      chk("range_drop_cnt", drop_range_cnt, 2);
`endif

      // Timestamp monotonicity.
      do_reset();
      st_q.delete(); st_cyc.delete();
      send(50, 1, 1, 0);
      send(50, 2, 2, 0);
      send(40, 3, 3, 0);
      send(60, 4, 4, 0);
      repeat (16) @(posedge clk);
      #1;
      chk("ts_count", st_q.size(), 3);
      if (st_q.size() == 3) begin
         chk("ts_0", st_q[0][48:17], 50);
         chk("ts_1", st_q[1][48:17], 50);
         chk("ts_2", st_q[2][48:17], 60);
      end
`ifdef EVT_STATS_EN
      chk("ts_drop_cnt", drop_ts_cnt, 1);
      chk("ts_range_cnt", drop_range_cnt, 0);
`endif

      // Fill to full with core stalled, then drain with paced strobes.
      st_q.delete(); st_cyc.delete();
      core_ready = 0;
      for (int i = 0; i < 16; i++) send(1000 + i, 8'(i), 8'(i), 1'(i));
      in_valid = 1; in_timestamp = 1016; in_x = 16; in_y = 16; in_polarity = 0;
      @(negedge clk);
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_level", fifo_level, 16);
      core_ready = 1;
      for (int i = 16; i < 20; i++) send(1000 + i, 8'(i), 8'(i), 1'(i));
      repeat (100) @(posedge clk);
      #1;
      chk("burst_count", st_q.size(), 20);
      for (int i = 0; i < st_q.size(); i++) chk("burst_order", st_q[i][48:17], 1000 + i);
      for (int i = 1; i < st_cyc.size(); i++) chk("burst_gap", st_cyc[i] - st_cyc[i-1], GAP);

      // Reset with buffered events.
      core_ready = 0;
      for (int i = 0; i < 5; i++) send(2000 + i, 8'(i), 8'(i), 0);
      @(negedge clk);
      chk("pre_reset_level", fifo_level, 5);
      core_ready = 1;
      reset      = 1;
      @(posedge clk);
      @(negedge clk);
      chk("post_reset_level", fifo_level, 0);
      chk("post_reset_valid", is_valid, 1'b0);
      @(posedge clk);
      #1;
      reset = 0;
      st_q.delete(); st_cyc.delete();
      send(0, 5, 6, 1);
      repeat (8) @(posedge clk);
      #1;
      chk("after_reset_count", st_q.size(), 1);
      if (st_q.size() > 0) chk("after_reset_fields", st_q[0], {32'd0, 8'd5, 8'd6, 1'b1});

      // ISSUE_GAP=1 instance: back-to-back strobes.
      g_in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         g_in_timestamp = 300 + i; g_in_x = 8'(i + 1); g_in_y = 1; g_in_polarity = 1;
         @(posedge clk);
         #1;
      end
      g_in_valid   = 0;
      chk("g1_level", g_fifo_level, 4);
      g_core_ready = 1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("g1_valid", g_is_valid, 1'b1);
         chk("g1_ts", g_timestamp, 300 + i);
      end
      @(negedge clk);
      chk("g1_valid_end", g_is_valid, 1'b0);
      chk("g1_level_end", g_fifo_level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
